// File: rtl/vagu_pkg.sv
// Shared definitions for the vector register-group address generator:
// vlmul encodings, group-size helper and FSM state type.
package vagu_pkg;

  localparam logic [2:0] LMUL1     = 3'b000;
  localparam logic [2:0] LMUL2     = 3'b001;
  localparam logic [2:0] LMUL4     = 3'b010;
  localparam logic [2:0] LMUL8     = 3'b011;
  localparam logic [2:0] FRAC_MASK = 3'b100;

  // Wide enough for the illegal widened LMUL8 case (16) so it can be flagged.
  localparam int unsigned GROUP_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  function automatic logic [GROUP_W-1:0] group_size(input logic [2:0] vlmul,
                                                    input logic       widen);
    logic [GROUP_W-1:0] g;
    if ((vlmul & FRAC_MASK) != 3'b000) g = GROUP_W'(1);
    else                               g = GROUP_W'(1) << vlmul[1:0];
    if (widen) g = g << 1;
    return g;
  endfunction

endpackage

// File: rtl/vagu_cfg_decode.sv
// Decodes a request into its last beat index and a reject flag
// (oversized widened group or base not aligned to the group size).
module vagu_cfg_decode
  import vagu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned MAX_GROUP_LOG = 3
) (
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic [2:0]               vlmul,
  input  logic                     widen,
  input  logic [MAX_GROUP_LOG:0]   reg_count,
  output logic [MAX_GROUP_LOG-1:0] last_idx,
  output logic                     reject
);

  logic [31:0] g32;
  logic [31:0] rc32;
  logic [31:0] base32;
  logic [31:0] n32;

  always_comb begin
    g32    = 32'(group_size(vlmul, widen));
    rc32   = 32'(reg_count);
    base32 = 32'(base_addr);
    // vl trims the group; zero or an oversized count means the whole group
    n32    = ((rc32 == 32'd0) || (rc32 >= g32)) ? g32 : rc32;
    last_idx = MAX_GROUP_LOG'(n32 - 32'd1);
    reject = (widen && (vlmul == LMUL8)) || ((base32 & (g32 - 32'd1)) != 32'd0);
  end

endmodule

// File: rtl/vreg_group_agu.sv
// Vector register-group address generator: accepts one group request and
// streams its register addresses, one per accepted beat.
module vreg_group_agu
  import vagu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned MAX_GROUP_LOG = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [2:0]             vlmul,
  input  logic                   widen,
  input  logic [MAX_GROUP_LOG:0] reg_count,
  input  logic                   abort,
  output logic [ADDR_WIDTH-1:0]  addr_out,
  output logic                   addr_valid,
  input  logic                   addr_ready,
  output logic                   addr_last,
  output logic                   idle,
  output logic                   err
);

  state_e                   state_q, state_d;
  logic [MAX_GROUP_LOG-1:0] cnt_q, cnt_d, cnt_inc;
  logic [MAX_GROUP_LOG-1:0] last_idx_q, last_idx_d;
  logic [MAX_GROUP_LOG-1:0] cfg_last_idx;
  logic                     cfg_reject;
  logic [ADDR_WIDTH-1:0]    addr_d;
  logic                     valid_d, last_d, idle_d, err_d;

  assign start_ready = idle;

  vagu_cfg_decode #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .MAX_GROUP_LOG(MAX_GROUP_LOG)
  ) u_cfg_decode (
    .base_addr(base_addr),
    .vlmul    (vlmul),
    .widen    (widen),
    .reg_count(reg_count),
    .last_idx (cfg_last_idx),
    .reject   (cfg_reject)
  );

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_idx_q <= '0;
      addr_out   <= '0;
      addr_valid <= 1'b0;
      addr_last  <= 1'b0;
      idle       <= 1'b1;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_idx_q <= last_idx_d;
      addr_out   <= addr_d;
      addr_valid <= valid_d;
      addr_last  <= last_d;
      idle       <= idle_d;
      err        <= err_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_idx_d = last_idx_q;
    addr_d     = addr_out;
    valid_d    = addr_valid;
    last_d     = addr_last;
    idle_d     = idle;
    err_d      = 1'b0;
    cnt_inc    = cnt_q + MAX_GROUP_LOG'(1);

    case (state_q)
      IDLE: begin
        if (start_valid && start_ready) begin
          if (cfg_reject) begin
            err_d = 1'b1;
          end else begin
            state_d    = ISSUE;
            cnt_d      = '0;
            last_idx_d = cfg_last_idx;
            addr_d     = base_addr;
            valid_d    = 1'b1;
            last_d     = (cfg_last_idx == '0);
            idle_d     = 1'b0;
          end
        end
      end
      ISSUE: begin
        // Abort wins over a same-cycle beat acceptance
        if (abort || (addr_ready && (cnt_q == last_idx_q))) begin
          state_d = IDLE;
          cnt_d   = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
          idle_d  = 1'b1;
        end else if (addr_ready) begin
          cnt_d  = cnt_inc;
          addr_d = addr_out + ADDR_WIDTH'(1);
          last_d = (cnt_inc == last_idx_q);
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        idle_d  = 1'b1;
      end
    endcase
  end

endmodule
